branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Consumes the 1-bit comparison result from the comparator, plus branch/jump operands from EX.
//  Decides taken/not-taken and computes the target PC.
//  Issues a held valid/ready redirect to fetch and holds a pipeline flush until the redirect completes.
//  Sits between EX (comparator/adder) and the fetch PC mux; sole source of control-flow redirects.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles flush stays high after redirect handshake (0 allowed)
//  CNT_W         32  width of statistics counters (used only with BRU_STATS_EN)
// PORTS
//  clk           in   1   clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  br_valid      in   1   EX presents a branch/jump this cycle
//  br_ready      out  1   unit can accept (high only in IDLE)
//  br_kind       in   2   00 cond branch, 01 JAL, 10 JALR, 11 reserved
//  comp          in   1   comparator result (1 = condition true)
//  pc            in   32  PC of the branch/jump
//  imm           in   32  sign-extended immediate
//  rs1           in   32  rs1 value (JALR base)
//  redir_valid   out  1   redirect request to fetch
//  redir_ready   in   1   fetch accepts redirect
//  redir_pc      out  32  redirect target; stable while redir_valid && !redir_ready
//  flush         out  1   squash younger in-flight instructions
//  misalign      out  1   1-cycle pulse: taken target not 4-byte aligned
//  trap_addr     out  32  offending target; valid when misalign=1
// BEHAVIOUR
//  Reset: state=IDLE; br_ready=1; redir_valid, flush, misalign=0; redir_pc, trap_addr=0.
//  Accept on br_valid && br_ready (cycle N); operands sampled that edge only.
//  Taken rules:
//   - JAL, JALR: always taken.
//   - cond branch: taken = comp.
//   - kind 11: accepted, treated as not taken, no output.
//  Target (32-bit, wraps mod 2^32, no overflow flag):
//   - branch/JAL: pc + imm.
//   - JALR: (rs1 + imm) & 32'hFFFF_FFFE.
//  Misaligned: target[1] == 1 (no compressed ext).
//  FSM IDLE / REDIRECT / FLUSH; flush_cnt counts down in FLUSH.
//  IDLE:
//   - not taken: stay IDLE, no outputs.
//   - taken + misaligned: misalign=1 and trap_addr=target in N+1; stay IDLE; no redirect, no flush.
//   - taken + aligned: go REDIRECT; in N+1 redir_valid=1, redir_pc=target, flush=1, br_ready=0.
//  REDIRECT:
//   - hold redir_valid, redir_pc and flush until redir_ready.
//   - on handshake: FLUSH_CYCLES=0 -> IDLE, else FLUSH with flush_cnt=FLUSH_CYCLES-1.
//   - redir_valid drops the cycle after the handshake.
//  FLUSH: flush=1; flush_cnt==0 -> IDLE, else decrement.
//   - total flush cycles after the handshake cycle = FLUSH_CYCLES.
//  IDLE has flush=0, br_ready=1.
//  br_valid while busy: ignored (br_ready=0); producer must hold.
//  redir_ready high in the first REDIRECT cycle: single-cycle handshake is legal.
//  rst_n low mid-operation: immediate return to reset values; pending redirect dropped.
//  Latency: accept -> redir_valid/misalign = 1 cycle.
// CONFIGURATION
//  BRU_STATS_EN defined:
//   - adds outputs taken_cnt [CNT_W-1:0] and nottaken_cnt [CNT_W-1:0], reset to 0.
//   - +1 per accepted cond branch, taken or not; wrap at 2^CNT_W.
//   - jumps and kind 11 are not counted; misaligned taken branches count as taken.
//  BRU_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. BEQ, comp=1, pc=0x100, imm=0x20, redir_ready=1:
//     -> redir_valid N+1, redir_pc=0x120; flush high N+1..N+3; br_ready back N+4.
//  2. Cond branch, comp=0 -> no redir_valid, flush or misalign; br_ready stays 1.
//  3. JALR rs1=0x1001, imm=0x3 -> redir_pc=0x1004.
//     JAL pc=0xFFFF_FFF0, imm=0x20 -> redir_pc=0x10 (wrap).
//  4. Taken target 0x202 -> misalign 1-cycle pulse, trap_addr=0x202; no redirect/flush.
//  5. redir_ready low 3 cycles:
//     -> redir_valid/redir_pc/flush held; br_valid meanwhile ignored; handshake on cycle 4.
//  6. rst_n low during REDIRECT -> all outputs at reset values asynchronously.
//     With BRU_STATS_EN: 3 taken + 2 not-taken -> taken_cnt=3, nottaken_cnt=2.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: decides taken/not-taken, computes the target and drives the
// fetch redirect handshake plus pipeline flush. Optional statistics via BRU_STATS_EN.
module branch_resolve_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [1:0]  br_kind,
    input  logic        comp,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    output logic        redir_valid,
    input  logic        redir_ready,
    output logic [31:0] redir_pc,
    output logic        flush,
    output logic        misalign,
    output logic [31:0] trap_addr
`ifdef BRU_STATS_EN
    ,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] nottaken_cnt
`endif
);

    localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDIRECT,
        S_FLUSH
    } state_e;

    localparam logic [1:0] K_BRANCH = 2'b00;
    localparam logic [1:0] K_JAL    = 2'b01;
    localparam logic [1:0] K_JALR   = 2'b10;

    state_e            state_q, state_d;
    logic [31:0]       redir_pc_q, redir_pc_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic              misalign_q, misalign_d;
    logic [31:0]       trap_addr_q, trap_addr_d;

    logic        accept;
    logic        taken;
    logic [31:0] target;

    assign accept = br_valid && (state_q == S_IDLE);
    assign taken  = (br_kind == K_JAL) || (br_kind == K_JALR) ||
                    ((br_kind == K_BRANCH) && comp);
    // JALR clears bit 0 of its sum; the misalign test only looks at bit 1.
    assign target = (br_kind == K_JALR) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        redir_pc_d  = redir_pc_q;
        flush_cnt_d = flush_cnt_q;
        misalign_d  = 1'b0;
        trap_addr_d = trap_addr_q;

        case (state_q)
            S_IDLE: begin
                if (accept && taken) begin
                    if (target[1]) begin
                        misalign_d  = 1'b1;
                        trap_addr_d = target;
                    end else begin
                        state_d    = S_REDIRECT;
                        redir_pc_d = target;
                    end
                end
            end
            S_REDIRECT: begin
                if (redir_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d     = S_FLUSH;
                        flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
                    end
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            redir_pc_q  <= '0;
            flush_cnt_q <= '0;
            misalign_q  <= 1'b0;
            trap_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            redir_pc_q  <= redir_pc_d;
            flush_cnt_q <= flush_cnt_d;
            misalign_q  <= misalign_d;
            trap_addr_q <= trap_addr_d;
        end
    end

    assign br_ready    = (state_q == S_IDLE);
    assign redir_valid = (state_q == S_REDIRECT);
    assign flush       = (state_q != S_IDLE);
    assign redir_pc    = redir_pc_q;
    assign misalign    = misalign_q;
    assign trap_addr   = trap_addr_q;

`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] nottaken_cnt_q, nottaken_cnt_d;

    // Only conditional branches count; misaligned taken ones still count as taken.
    always_comb begin
        taken_cnt_d    = taken_cnt_q;
        nottaken_cnt_d = nottaken_cnt_q;
        if (accept && (br_kind == K_BRANCH)) begin
            if (comp) taken_cnt_d    = taken_cnt_q + CNT_W'(1);
            else      nottaken_cnt_d = nottaken_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q    <= '0;
            nottaken_cnt_q <= '0;
        end else begin
            taken_cnt_q    <= taken_cnt_d;
            nottaken_cnt_q <= nottaken_cnt_d;
        end
    end

    assign taken_cnt    = taken_cnt_q;
    assign nottaken_cnt = nottaken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table for single branches plus
// hand-written sequences for flush timing, back-pressure, async reset and statistics.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic        br_ready;
    logic [1:0]  br_kind;
    logic        comp;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        flush;
    logic        misalign;
    logic [31:0] trap_addr;
`ifdef BRU_STATS_EN
    logic [31:0] taken_cnt;
    logic [31:0] nottaken_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .br_valid    (br_valid),
        .br_ready    (br_ready),
        .br_kind     (br_kind),
        .comp        (comp),
        .pc          (pc),
        .imm         (imm),
        .rs1         (rs1),
        .redir_valid (redir_valid),
        .redir_ready (redir_ready),
        .redir_pc    (redir_pc),
        .flush       (flush),
        .misalign    (misalign),
        .trap_addr   (trap_addr)
`ifdef BRU_STATS_EN
        ,
        .taken_cnt   (taken_cnt),
        .nottaken_cnt(nottaken_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic        comp;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        exp_redir;
        logic [31:0] exp_pc;
        logic        exp_mis;
        logic [31:0] exp_trap;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts and ends at posedge+1; presents one branch for exactly one accept edge.
    task automatic issue(input logic [1:0] k, input logic c, input logic [31:0] p,
                         input logic [31:0] i, input logic [31:0] r);
        br_valid = 1'b1;
        br_kind  = k;
        comp     = c;
        pc       = p;
        imm      = i;
        rs1      = r;
        @(posedge clk);
        #1;
        br_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!br_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_idle_timeout", 32'(br_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b00, 1'b1, 32'h0000_0100, 32'h0000_0020, 32'h0, 1'b1, 32'h0000_0120, 1'b0, 32'h0};
        vecs[1] = '{2'b00, 1'b0, 32'h0000_0100, 32'h0000_0020, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[2] = '{2'b10, 1'b0, 32'h0000_0000, 32'h0000_0003, 32'h0000_1001, 1'b1, 32'h0000_1004, 1'b0, 32'h0};
        vecs[3] = '{2'b01, 1'b0, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0, 1'b1, 32'h0000_0010, 1'b0, 32'h0};
        vecs[4] = '{2'b00, 1'b1, 32'h0000_0200, 32'h0000_0002, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0202};
        vecs[5] = '{2'b11, 1'b1, 32'h0000_0400, 32'h0000_0010, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[6] = '{2'b01, 1'b0, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0000_0FFC, 1'b0, 32'h0};
        vecs[7] = '{2'b10, 1'b0, 32'h0000_0000, 32'h0000_0003, 32'h0000_2000, 1'b0, 32'h0, 1'b1, 32'h0000_2002};
        vecs[8] = '{2'b01, 1'b0, 32'h0000_0010, 32'h0000_0006, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0016};

        rst_n = 1'b0; br_valid = 1'b0; br_kind = 2'b00; comp = 1'b0;
        pc = '0; imm = '0; rs1 = '0; redir_ready = 1'b1;
        #2;
        check("rst_br_ready", 32'(br_ready), 32'd1);
        check("rst_redir_valid", 32'(redir_valid), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_redir_pc", redir_pc, 32'd0);
        check("rst_trap_addr", trap_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-branch vectors, fetch always ready.
        for (int v = 0; v < 9; v++) begin
            issue(vecs[v].kind, vecs[v].comp, vecs[v].pc, vecs[v].imm, vecs[v].rs1);
            check($sformatf("v%0d_redir_valid", v), 32'(redir_valid), 32'(vecs[v].exp_redir));
            check($sformatf("v%0d_flush", v), 32'(flush), 32'(vecs[v].exp_redir));
            check($sformatf("v%0d_br_ready", v), 32'(br_ready), 32'(!vecs[v].exp_redir));
            check($sformatf("v%0d_misalign", v), 32'(misalign), 32'(vecs[v].exp_mis));
            if (vecs[v].exp_redir)
                check($sformatf("v%0d_redir_pc", v), redir_pc, vecs[v].exp_pc);
            if (vecs[v].exp_mis)
                check($sformatf("v%0d_trap_addr", v), trap_addr, vecs[v].exp_trap);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_misalign_pulse_end", v), 32'(misalign), 32'd0);
            wait_idle();
        end

        // Flush timing with immediate handshake: flush N+1..N+3, br_ready back at N+4.
        issue(2'b00, 1'b1, 32'h100, 32'h20, 32'h0);
        check("t1_n1_valid", 32'(redir_valid), 32'd1);
        check("t1_n1_flush", 32'(flush), 32'd1);
        @(posedge clk); #1;
        check("t1_n2_valid", 32'(redir_valid), 32'd0);
        check("t1_n2_flush", 32'(flush), 32'd1);
        check("t1_n2_ready", 32'(br_ready), 32'd0);
        @(posedge clk); #1;
        check("t1_n3_flush", 32'(flush), 32'd1);
        check("t1_n3_ready", 32'(br_ready), 32'd0);
        @(posedge clk); #1;
        check("t1_n4_flush", 32'(flush), 32'd0);
        check("t1_n4_ready", 32'(br_ready), 32'd1);

        // Back-pressure: fetch stalls 3 cycles while a second branch is ignored.
        redir_ready = 1'b0;
        issue(2'b00, 1'b1, 32'h300, 32'h40, 32'h0);
        br_valid = 1'b1; br_kind = 2'b01; pc = 32'h5000; imm = 32'h0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("t5_c%0d_valid", c), 32'(redir_valid), 32'd1);
            check($sformatf("t5_c%0d_pc", c), redir_pc, 32'h340);
            check($sformatf("t5_c%0d_flush", c), 32'(flush), 32'd1);
            check($sformatf("t5_c%0d_ready", c), 32'(br_ready), 32'd0);
            @(posedge clk); #1;
        end
        br_valid = 1'b0;
        redir_ready = 1'b1;
        check("t5_hs_valid", 32'(redir_valid), 32'd1);
        check("t5_hs_pc", redir_pc, 32'h340);
        @(posedge clk); #1;
        check("t5_post_valid", 32'(redir_valid), 32'd0);
        check("t5_post_flush", 32'(flush), 32'd1);
        @(posedge clk); #1;
        check("t5_post2_flush", 32'(flush), 32'd1);
        @(posedge clk); #1;
        check("t5_idle_flush", 32'(flush), 32'd0);
        check("t5_idle_ready", 32'(br_ready), 32'd1);
        @(posedge clk); #1;
        check("t5_no_second_redirect", 32'(redir_valid), 32'd0);

        // Asynchronous reset in REDIRECT drops the pending redirect at once.
        redir_ready = 1'b0;
        issue(2'b01, 1'b0, 32'h40, 32'h10, 32'h0);
        check("t6_pre_valid", 32'(redir_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(redir_valid), 32'd0);
        check("t6_rst_flush", 32'(flush), 32'd0);
        check("t6_rst_ready", 32'(br_ready), 32'd1);
        check("t6_rst_redir_pc", redir_pc, 32'd0);
        check("t6_rst_misalign", 32'(misalign), 32'd0);
        check("t6_rst_trap_addr", trap_addr, 32'd0);
        redir_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_after_valid", 32'(redir_valid), 32'd0);
        check("t6_after_ready", 32'(br_ready), 32'd1);

`ifdef BRU_STATS_EN
        issue(2'b00, 1'b1, 32'h100, 32'h8, 32'h0); wait_idle();
        issue(2'b00, 1'b1, 32'h200, 32'h8, 32'h0); wait_idle();
        issue(2'b00, 1'b1, 32'h100, 32'h2, 32'h0); wait_idle();
        issue(2'b00, 1'b0, 32'h100, 32'h8, 32'h0); wait_idle();
        issue(2'b00, 1'b0, 32'h100, 32'h8, 32'h0); wait_idle();
        issue(2'b01, 1'b0, 32'h100, 32'h8, 32'h0); wait_idle();
        issue(2'b11, 1'b1, 32'h100, 32'h8, 32'h0); wait_idle();
        check("stats_taken", taken_cnt, 32'd3);
        check("stats_nottaken", nottaken_cnt, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
